// File: rtl/switch_box_config_loader_pkg.sv
// Shared types and constants for the switch box configuration loader.
// Holds the loader state encoding, the CRC-8 polynomial and the beat-count helper.
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } sb_cfg_state_e;

  localparam logic [7:0] SB_CFG_CRC_POLY = 8'h07;

  // Payload beats needed to cover the config word; the last beat may carry pad bits.
  function automatic int sb_cfg_nbeats(input int conf_width, input int in_width);
    return (conf_width + in_width - 1) / in_width;
  endfunction

endpackage

// File: rtl/switch_box_config_loader_if.sv
// Beat stream in, config word out: the loader is the slave, the fabric
// configuration controller (or a bench) is the master.
interface switch_box_config_loader_if #(
  parameter int CONF_WIDTH = 48,
  parameter int IN_WIDTH   = 8
);
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  abort;
  logic [CONF_WIDTH-1:0] c;
  logic                  cset;
  logic                  busy;
  logic                  err;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, c, cset, busy, err
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, c, cset, busy, err
  );
endinterface

// File: rtl/switch_box_config_loader_crc8.sv
// Registered CRC-8 (MSB-first, init 0x00) over one byte per enabled cycle.
// Only instantiated by the loader when SB_CFG_LOADER_CRC_EN is defined.
module sb_cfg_crc8
  import sb_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in, input logic [7:0] din);
    logic [7:0] r;
    r = crc_in ^ din;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ SB_CFG_CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc8_update(crc_q, data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/switch_box_config_loader.sv
// Serial-to-parallel writer for the switch box config port: packs beats LSB-first
// into c and fires a one-cycle cset. Define SB_CFG_LOADER_CRC_EN for a CRC-8 trailer.
module switch_box_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int W          = 8,
  parameter int CONF_WIDTH = 6 * W,
  parameter int IN_WIDTH   = 8
) (
  input logic                      clk,
  input logic                      rst,
  switch_box_config_loader_if.slave bus
);

  localparam int NBEATS = sb_cfg_nbeats(CONF_WIDTH, IN_WIDTH);
  localparam int CW     = $clog2(NBEATS + 1);
  localparam int PADW   = NBEATS * IN_WIDTH;

  sb_cfg_state_e         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CONF_WIDTH-1:0] c_q, c_d;
  logic                  cset_q, cset_d;
  logic [PADW-1:0]       c_pad;
  logic                  in_ready;
  logic                  accept;
  logic                  payload_beat;

  assign in_ready = ((state_q == IDLE) || (state_q == LOAD)) && !bus.abort && !rst;
  assign accept   = bus.in_valid && in_ready;

`ifdef SB_CFG_LOADER_CRC_EN
  logic       trailer_beat;
  logic       crc_ok;
  logic       err_q, err_d;
  logic [7:0] crc_val;

  if (IN_WIDTH != 8) begin : g_crc_width_check
    $error("SB_CFG_LOADER_CRC_EN requires IN_WIDTH == 8");
  end

  // Beats past the payload count are the CRC trailer.
  assign payload_beat = accept && (cnt_q < CW'(NBEATS));
  assign trailer_beat = accept && (cnt_q == CW'(NBEATS));
  assign crc_ok       = (bus.in_data == crc_val);

  sb_cfg_crc8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.abort || trailer_beat),
    .en   (payload_beat),
    .data (bus.in_data),
    .crc  (crc_val)
  );
`else
  assign payload_beat = accept;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef SB_CFG_LOADER_CRC_EN
    err_d   = 1'b0;
`endif

    // Bits beyond CONF_WIDTH in the final beat fall into the pad and are dropped.
    c_pad                   = '0;
    c_pad[CONF_WIDTH-1:0]   = c_q;
    if (payload_beat) begin
      for (int k = 0; k < NBEATS; k++) begin
        if (cnt_q == CW'(k)) begin
          c_pad[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
        end
      end
    end
    c_d = c_pad[CONF_WIDTH-1:0];

    case (state_q)
      IDLE, LOAD: begin
        if (payload_beat) begin
`ifdef SB_CFG_LOADER_CRC_EN
          cnt_d   = cnt_q + CW'(1);
          state_d = LOAD;
        end else if (trailer_beat) begin
          cnt_d = '0;
          if (crc_ok) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
`else
          if (cnt_q == CW'(NBEATS - 1)) begin
            cnt_d   = '0;
            state_d = COMMIT;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = LOAD;
          end
`endif
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    cset_d = (state_d == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      cset_q  <= 1'b0;
`ifdef SB_CFG_LOADER_CRC_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cset_q  <= cset_d;
`ifdef SB_CFG_LOADER_CRC_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.c        = c_q;
  assign bus.cset     = cset_q;
  assign bus.busy     = (state_q != IDLE);
`ifdef SB_CFG_LOADER_CRC_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Self-checking bench for switch_box_config_loader (W=8, 48-bit word, 8-bit beats).
// Expected commits are queued as frames are sent and popped when cset is seen.
module tb_switch_box_config_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_box_config_loader_if #(.CONF_WIDTH(48), .IN_WIDTH(8)) bus ();

  switch_box_config_loader #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp   = 0;
  int          n_fail  = 0;
  int          exp_err = 0;
  logic [47:0] exp_q[$];

`ifdef SB_CFG_LOADER_CRC_EN
  function automatic logic [7:0] crc8_model(input logic [7:0] b[6]);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 6; k++) begin
      r = r ^ b[k];
      for (int i = 0; i < 8; i++) begin
        if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
        else      r = {r[6:0], 1'b0};
      end
    end
    return r;
  endfunction
`endif

  // One clock edge, then the scoreboard looks at whatever strobes the DUT raised.
  task automatic tick();
    logic [47:0] e;
    @(posedge clk);
    #1;
    if (bus.cset === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cset: c=%h, required no strobe", bus.c);
      end else begin
        e = exp_q.pop_front();
        if (bus.c !== e) begin
          n_fail++;
          $display("FAIL commit_word: c=%h, required %h", bus.c, e);
        end
      end
    end
    if (bus.err === 1'b1) begin
      n_cmp++;
      if (exp_err == 0) begin
        n_fail++;
        $display("FAIL unexpected_err: err=1, required 0");
      end else begin
        exp_err--;
      end
    end
    if (bus.cset === 1'b1 && bus.err === 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cset_err_overlap: both high, required never together");
    end
  endtask

  task automatic send_beat(input logic [7:0] d);
    int budget;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, budget);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[6], input bit stall, input bit bad);
    logic [47:0] word;
`ifdef SB_CFG_LOADER_CRC_EN
    logic [7:0] trailer;
`endif
    for (int k = 0; k < 6; k++) word[k*8 +: 8] = b[k];
    for (int k = 0; k < 6; k++) begin
      if (stall) repeat ($urandom_range(0, 3)) tick();
`ifndef SB_CFG_LOADER_CRC_EN
      if (k == 5) exp_q.push_back(word);
`endif
      send_beat(b[k]);
    end
`ifdef SB_CFG_LOADER_CRC_EN
    if (stall) repeat ($urandom_range(0, 3)) tick();
    trailer = crc8_model(b);
    if (bad) begin
      trailer = trailer ^ 8'h01;
      exp_err++;
    end else begin
      exp_q.push_back(word);
    end
    send_beat(trailer);
`endif
  endtask

  task automatic check_commit(input string name, input logic [47:0] e);
    n_cmp++;
    if (bus.cset !== 1'b1 || bus.c !== e) begin
      n_fail++;
      $display("FAIL %s: cset=%b c=%h, required cset=1 c=%h", name, bus.cset, bus.c, e);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_commit_flags: in_ready=%b busy=%b, required 0/1", name, bus.in_ready, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.cset !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after_commit: cset=%b busy=%b in_ready=%b, required 0/0/1",
               name, bus.cset, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.abort    = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.c !== 48'h0 || bus.cset !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: c=%h cset=%b err=%b busy=%b, required 0", bus.c, bus.cset, bus.err, bus.busy);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b during rst, required 0", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[6];
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(b, 1'b0, 1'b0);
    check_commit("b2b_frame", 48'h060504030201);
    b = '{8'hC3, 8'h5A, 8'hFF, 8'h00, 8'h81, 8'h7E};
    send_frame(b, 1'b0, 1'b0);
    check_commit("b2b_frame2", 48'h7E8100FF5AC3);
  endtask

  task automatic test_stall();
    logic [7:0] b[6];
    b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_frame(b, 1'b1, 1'b0);
    check_commit("stall_frame", 48'hA5A4A3A2A1A0);
    repeat (4) tick();
  endtask

  task automatic test_abort();
    logic [7:0] b[6];
    send_beat(8'h20);
    send_beat(8'h21);
    send_beat(8'h22);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: busy=%b, required 1", bus.busy);
    end
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: in_ready=%b, required 0", bus.in_ready);
    end
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.cset !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b cset=%b, required 0/0", bus.busy, bus.cset);
    end
    b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send_frame(b, 1'b0, 1'b0);
    check_commit("abort_next_frame", 48'h161514131211);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b[6];
    send_beat(8'h41);
    send_beat(8'h42);
    send_beat(8'h43);
    send_beat(8'h44);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.c !== 48'h0 || bus.cset !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: c=%h cset=%b busy=%b, required 0", bus.c, bus.cset, bus.busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: in_ready=%b, required 1", bus.in_ready);
    end
    repeat (3) tick();
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    send_frame(b, 1'b0, 1'b0);
    check_commit("midreset_next_frame", 48'h363534333231);
  endtask

`ifdef SB_CFG_LOADER_CRC_EN
  task automatic test_crc();
    logic [7:0] b[6];
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(b, 1'b0, 1'b0);
    check_commit("crc_good", 48'h060504030201);
    send_frame(b, 1'b0, 1'b1);
    n_cmp++;
    if (bus.err !== 1'b1 || bus.cset !== 1'b0) begin
      n_fail++;
      $display("FAIL crc_bad_pulse: err=%b cset=%b, required 1/0", bus.err, bus.cset);
    end
    tick();
    n_cmp++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.cset !== 1'b0) begin
      n_fail++;
      $display("FAIL crc_bad_after: err=%b busy=%b cset=%b, required 0/0/0", bus.err, bus.busy, bus.cset);
    end
    send_frame(b, 1'b1, 1'b0);
    check_commit("crc_recover", 48'h060504030201);
  endtask
`else
  task automatic test_err_tied();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_tied: err=%b, required 0", bus.err);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid_frame();
`ifdef SB_CFG_LOADER_CRC_EN
    test_crc();
`else
    test_err_tied();
`endif
    repeat (4) tick();
    n_cmp++;
    if (exp_q.size() != 0 || exp_err != 0) begin
      n_fail++;
      $display("FAIL missing_strobes: %0d commits and %0d errs outstanding, required 0", exp_q.size(), exp_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_box_config_loader.md
# switch_box_config_loader

Serial-to-parallel configuration writer for the disjoint switch box config port. It accepts a configuration frame as a stream of `IN_WIDTH`-bit beats over a valid/ready handshake and assembles them into a `CONF_WIDTH`-bit word. It then drives that word on `c` with a one-cycle `cset` strobe, which is the exact load protocol the switch box expects. One loader sits per switch box, or per chain segment, between the fabric configuration controller and the switch box.

## Interface
Parameters:
- `W`, 8, fabric wires per side of the target switch box.
- `CONF_WIDTH`, 6*W, width of the target config word.
- `IN_WIDTH`, 8, beat width of the input stream.
- `NBEATS`, ceil(`CONF_WIDTH`/`IN_WIDTH`), payload beats per frame; derived, not overridden.

Ports:
- `clk`, input, 1, clock.
- `rst`, input, 1, synchronous, active-high reset.
- `in_data`, input, `IN_WIDTH`, payload beat.
- `in_valid`, input, 1, beat present.
- `in_ready`, output, 1, loader can accept a beat.
- `abort`, input, 1, discard any partial frame.
- `c`, output, `CONF_WIDTH`, assembled config word; connects to switch box `c`.
- `cset`, output, 1, one-cycle commit strobe; connects to switch box `cset`.
- `busy`, output, 1, a frame is partially loaded or committing.
- `err`, output, 1, one-cycle pulse on a rejected frame.

## Operation
- States:
  - `IDLE`: no partial frame.
  - `LOAD`: 1..`NBEATS`-1 payload beats held, or the CRC trailer is awaited.
  - `COMMIT`: one cycle, `cset`=1.
- Beat accept rule: a beat is accepted on a rising edge with `in_valid`&&`in_ready`.
- `in_ready` = (state is `IDLE` or `LOAD`) && !`abort` && !`rst`.
- Beat k (0-based) is written to `c[k*IN_WIDTH +: IN_WIDTH]`, so the first beat is LSB.
  - In the final beat, bits beyond `CONF_WIDTH` are dropped.
  - Bits of `c` not yet written in the current frame keep their previous value.
- Beat counter: width $clog2(`NBEATS`+1). It increments per accepted payload beat and clears on commit, reject, abort and reset.
- Transitions:
  - `IDLE` goes to `LOAD` on the first accepted beat. If `NBEATS`==1 without CRC, it goes directly to `COMMIT`.
  - `LOAD` goes to `COMMIT` when the last payload beat is accepted.
  - With CRC, `LOAD` goes to `COMMIT` only on trailer accept with a CRC match (see Configuration).
  - `COMMIT` goes to `IDLE` unconditionally.
- Abort: `abort`=1 in any state forces `IDLE` on the next edge.
  - Any beat presented in the same cycle is not accepted, because `in_ready`=0.
  - If `abort` arrives during `COMMIT`, the `cset` pulse in that cycle still occurs, since the strobe is already registered.
- `busy` = state != `IDLE`.
- `c` is stable and valid throughout the cycle in which `cset`=1. It is undefined as config outside that cycle.

## Timing
- Reset values: state `IDLE`, counter 0, `c`=0, `cset`=0, `err`=0, `busy`=0, `in_ready`=0 while `rst` is high.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Latency: the last payload beat (or the trailer, with CRC) is accepted at edge N, and `cset`=1 for the cycle following edge N.
- `in_ready`=0 during `COMMIT`. The earliest first beat of the next frame is accepted at edge N+2.
- Sustained throughput is one frame per `NBEATS`+1 cycles, or `NBEATS`+2 with CRC.
- `cset` and `err` are registered, never combinational from inputs. Both are exactly one cycle wide and are never high together.
- Reset mid-frame drops the partial frame and produces no `cset`.

## Configuration
- Macro: `SB_CFG_LOADER_CRC_EN`.
- Defined:
  - Each frame carries one extra trailer beat after the payload, holding CRC-8 (poly 0x07, init 0x00, MSB-first) over all `NBEATS` payload beats, including pad bits as sent.
  - The CRC is updated per accepted payload beat.
  - On trailer accept, a match produces `COMMIT`.
  - A mismatch produces an `err` pulse in the next cycle, no `cset`, and a return to `IDLE`.
  - CRC logic is only valid with `IN_WIDTH`==8; other widths are an elaboration error.
- Undefined: there is no trailer beat, `err` is tied 0, and no CRC logic is instantiated.

## Structure
- Package `sb_cfg_pkg` holds:
  - the state enum (`IDLE`, `LOAD`, `COMMIT`);
  - the constant `SB_CFG_CRC_POLY` = 8'h07;
  - the function computing `NBEATS` from `CONF_WIDTH`/`IN_WIDTH`.
- Sub-module `sb_cfg_crc8`: one-byte combinational CRC-8 update plus a registered CRC state with clear and enable. It is instantiated only under `SB_CFG_LOADER_CRC_EN`.

## Test plan
- W=8 (`CONF_WIDTH`=48), no CRC: send beats 0x01..0x06 back-to-back -> `cset`=1 for exactly one cycle, the cycle after the 6th accept, with `c`=48'h060504030201; `in_ready`=0 in that cycle.
- Stall stress: random `in_valid` gaps between the six beats 0xA0..0xA5 -> the same single `cset` with `c`=48'hA5A4A3A2A1A0; no extra or early strobe.
- Abort: three beats accepted, then `abort`=1 with `in_valid`=1 -> that beat is not accepted and `busy`=0 next cycle; a following clean frame 0x11..0x16 commits `c`=48'h161514131211.
- Reset mid-frame: four beats, then `rst` for one cycle -> `c`=0, no `cset`; `in_ready`=1 the cycle after `rst` deasserts.
- `SB_CFG_LOADER_CRC_EN`: frame 0x01..0x06 plus the correct CRC trailer from the bench model -> `cset` with `c`=48'h060504030201. The same frame with the trailer bit 0 flipped -> one `err` pulse, no `cset`, and `IDLE` the next cycle.
